// File: rtl/out_wbuf_pkg.sv
// Shared definitions for the buffered character-output front-end.
// Holds the drain FSM state encoding, the default peripheral and status
// addresses, the status word field positions and a small helper.
package out_wbuf_pkg;

    // Drain FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Default address map.
    localparam logic [31:0] OUT_ADDR_DEF  = 32'h0003_4560;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h0003_4564;

    // Status word field positions.
    localparam int OVF_BIT   = 31;
    localparam int DROP_LSB  = 16;
    localparam int LEVEL_LSB = 0;

    // Saturating 8-bit increment for the dropped-store counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/out_wbuf_if.sv
// Simple data-port bus used on both sides of out_wbuf.
// Signals:
//   daddr  - address (master -> slave)
//   dwdata - store data (master -> slave)
//   dwe    - byte write enables, nonzero means store (master -> slave)
//   drdata - read data (slave -> master)
interface out_wbuf_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport master (
        output daddr,
        output dwdata,
        output dwe,
        input  drdata
    );

    modport slave (
        input  daddr,
        input  dwdata,
        input  dwe,
        output drdata
    );
endinterface

// File: rtl/out_wbuf_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset (pointers and level)
//   push  - write wdata at the tail (ignored when full)
//   pop   - advance the head (ignored when empty)
//   wdata - data to write
//   rdata - data at the head (combinational)
//   full  - level == DEPTH
//   empty - level == 0
//   level - current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [LW-1:0] LVL_ONE = 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the level counter defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/out_wbuf.sv
// Buffered store front-end for the character output peripheral.
// CPU stores to OUT_ADDR are queued in a FIFO in one cycle; a drain FSM
// replays them to the peripheral, inserting PACE idle cycles after each.
// A full buffer drops the store (never stalls) and records it in status.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, clears all state
//   cpu    - CPU data port (slave side); drdata is combinational
//   periph - peripheral port (master side); driven only in ISSUE
// Status word: [31] overflow, [23:16] drop_cnt, [7:0] level.
module out_wbuf
    import out_wbuf_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          PACE      = 3,
    parameter logic [31:0] OUT_ADDR  = OUT_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic      clk,
    input  logic      reset,
    out_wbuf_if.slave  cpu,
    out_wbuf_if.master periph
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_ONE  = 1;
    localparam logic [7:0]    GAP_LOAD = (PACE > 0) ? 8'(PACE - 1) : 8'd0;

    state_e      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_q, drop_d;

    logic        store, push_req, stat_wr;
    logic        fifo_push, fifo_pop, drop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic [31:0] status;
    logic        unused_dwdata;

    assign store     = (cpu.dwe != 4'b0000);
    assign push_req  = store && (cpu.daddr == OUT_ADDR);
    assign stat_wr   = store && (cpu.daddr == STAT_ADDR);
    // Fullness is sampled before any same-edge pop, so a store that meets
    // a full FIFO is dropped even while ISSUE frees a slot.
    assign fifo_push = push_req && !fifo_full;
    assign drop      = push_req && fifo_full;
    assign fifo_pop  = (state_q == ISSUE);

    assign unused_dwdata = ^cpu.dwdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cpu.dwdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (PACE == 0) begin
                    // Level after this edge's pop (and any same-edge push).
                    state_d = ((fifo_level > LVL_ONE) || fifo_push) ? ISSUE : IDLE;
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = fifo_empty ? IDLE : ISSUE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (stat_wr) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gap_q   <= 8'd0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        status = 32'd0;
        status[OVF_BIT]          = ovf_q;
        status[DROP_LSB +: 8]    = drop_q;
        status[LEVEL_LSB +: 8]   = 8'(fifo_level);
    end

    always_comb begin
        if (cpu.daddr == STAT_ADDR)     cpu.drdata = status;
        else if (cpu.daddr == OUT_ADDR) cpu.drdata = periph.drdata;
        else                            cpu.drdata = 32'd0;
    end

    // Peripheral outputs decode straight from the state register so an
    // asynchronous reset removes the write strobe immediately.
    assign periph.daddr  = (state_q == ISSUE) ? OUT_ADDR : 32'd0;
    assign periph.dwdata = (state_q == ISSUE) ? {24'd0, fifo_rdata} : 32'd0;
    assign periph.dwe    = (state_q == ISSUE) ? 4'b0001 : 4'b0000;

endmodule

// File: tb/tb_out_wbuf.sv
module tb_out_wbuf;
    import out_wbuf_pkg::*;

    localparam logic [31:0] OUT  = 32'h0003_4560;
    localparam logic [31:0] STAT = 32'h0003_4564;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    out_wbuf_if cpu_a ();
    out_wbuf_if per_a ();
    out_wbuf_if cpu_b ();
    out_wbuf_if per_b ();

    out_wbuf #(.DEPTH(8), .PACE(3)) u_p3 (
        .clk    (clk),
        .reset  (reset),
        .cpu    (cpu_a),
        .periph (per_a)
    );

    out_wbuf #(.DEPTH(8), .PACE(255)) u_p255 (
        .clk    (clk),
        .reset  (reset),
        .cpu    (cpu_b),
        .periph (per_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] we);
        if (sel == 0) begin
            cpu_a.daddr = addr; cpu_a.dwdata = wd; cpu_a.dwe = we;
        end else begin
            cpu_b.daddr = addr; cpu_b.dwdata = wd; cpu_b.dwe = we;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int          pulse_at [3];
    logic [31:0] pulse_dat [3];
    int          npulse;
    bit          found;
    int          stray;

    initial begin
        drive(0, 32'd0, 32'd0, 4'd0);
        drive(1, 32'd0, 32'd0, 4'd0);
        per_a.drdata = 32'd0;
        per_b.drdata = 32'd0;

        // Reset state
        tick; tick;
        drive(0, STAT, 32'd0, 4'd0);
        drive(1, STAT, 32'd0, 4'd0);
        @(negedge clk);
        check("rst_status_a", cpu_a.drdata, 32'h0);
        check("rst_status_b", cpu_b.drdata, 32'h0);
        check("rst_dwe_a", {28'd0, per_a.dwe}, 32'h0);
        check("rst_daddr_a", per_a.daddr, 32'h0);
        check("rst_dwdata_a", per_a.dwdata, 32'h0);
        tick;
        reset = 1'b1;

        // Single store of 'A'
        drive(0, OUT, 32'hFFFF_FF41, 4'b0001);
        tick;
        drive(0, STAT, 32'd0, 4'd0);
        @(negedge clk);
        check("single_level1", cpu_a.drdata, 32'h1);
        check("single_idle_dwe", {28'd0, per_a.dwe}, 32'h0);
        tick;
        @(negedge clk);
        check("single_issue_dwe", {28'd0, per_a.dwe}, 32'h1);
        check("single_issue_data", per_a.dwdata, 32'h41);
        check("single_issue_addr", per_a.daddr, OUT);
        check("single_issue_level", cpu_a.drdata, 32'h1);
        tick;
        @(negedge clk);
        check("single_after_dwe", {28'd0, per_a.dwe}, 32'h0);
        check("single_after_level", cpu_a.drdata, 32'h0);
        repeat (5) tick;

        // Three back-to-back stores, PACE=3
        npulse = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 3) drive(0, OUT, 32'h41 + i, 4'b0001);
            else       drive(0, 32'd0, 32'd0, 4'd0);
            @(negedge clk);
            if (per_a.dwe != 4'd0) begin
                if (npulse < 3) begin
                    pulse_at[npulse]  = i;
                    pulse_dat[npulse] = per_a.dwdata;
                end
                npulse++;
            end
            tick;
        end
        check("pace_count", npulse, 32'd3);
        check("pace_t0", pulse_at[0], 32'd2);
        check("pace_t1", pulse_at[1], 32'd6);
        check("pace_t2", pulse_at[2], 32'd10);
        check("pace_d0", pulse_dat[0], 32'h41);
        check("pace_d1", pulse_dat[1], 32'h42);
        check("pace_d2", pulse_dat[2], 32'h43);

        // Read mux
        per_a.drdata = 32'd7;
        drive(0, OUT, 32'd0, 4'd0);
        @(negedge clk);
        check("rd_out_pass", cpu_a.drdata, 32'd7);
        tick;
        drive(0, 32'h0000_0100, 32'd0, 4'd0);
        @(negedge clk);
        check("rd_unmapped", cpu_a.drdata, 32'd0);
        tick;

        // Overflow with PACE=255: start a drain so the FSM sits in GAP
        drive(1, OUT, 32'h30, 4'b0001);
        tick;
        drive(1, 32'd0, 32'd0, 4'd0);
        tick;
        tick;
        for (int i = 0; i < 10; i++) begin
            drive(1, OUT, 32'h50 + i, 4'b0001);
            tick;
        end
        drive(1, STAT, 32'd0, 4'd0);
        @(negedge clk);
        check("ovf_status", cpu_b.drdata, 32'h8002_0008);
        tick;
        drive(1, STAT, 32'hFFFF_FFFF, 4'b1111);
        tick;
        drive(1, STAT, 32'd0, 4'd0);
        @(negedge clk);
        check("stat_clear", cpu_b.drdata, 32'h0000_0008);

        // Store while full during ISSUE -> dropped
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (per_b.dwe != 4'd0) found = 1'b1;
        end
        check("issue_seen_1", {31'd0, found}, 32'h1);
        check("order_head_50", per_b.dwdata, 32'h50);
        drive(1, OUT, 32'h77, 4'b0001);
        tick;
        drive(1, STAT, 32'd0, 4'd0);
        @(negedge clk);
        check("full_pop_drop", cpu_b.drdata, 32'h8001_0007);

        // Reset in the middle of ISSUE
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (per_b.dwe != 4'd0) found = 1'b1;
        end
        check("issue_seen_2", {31'd0, found}, 32'h1);
        check("order_next_51", per_b.dwdata, 32'h51);
        reset = 1'b0;
        #1;
        check("async_rst_dwe", {28'd0, per_b.dwe}, 32'h0);
        check("async_rst_status", cpu_b.drdata, 32'h0);
        tick;
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (per_b.dwe != 4'd0) stray++;
        end
        check("post_rst_no_write", stray, 32'd0);
        check("post_rst_status", cpu_b.drdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
